// File: rtl/concatena_asigna_concatena_unit_if.sv
// Operand/result bundle for the concatenated accumulate/load/rotate unit.
// The master drives Tupla/Operacion and observes Respuesta/Cy_Rta. There is no handshake: the unit samples every rising edge.
interface concatena_asigna_concatena_unit_if #(
  parameter int ANCHO = 3
);
  logic [ANCHO-1:0] Tupla;
  logic [1:0]       Operacion;
  logic [ANCHO-1:0] Respuesta;
  logic             Cy_Rta;

  modport master (
    output Tupla,
    output Operacion,
    input  Respuesta,
    input  Cy_Rta
  );

  modport slave (
    input  Tupla,
    input  Operacion,
    output Respuesta,
    output Cy_Rta
  );
endinterface

// File: rtl/concatena_asigna_concatena_unit.sv
// Registered ANCHO-bit accumulate/load/rotate-through-carry unit.
// The whole state is the single word {Cy_Rta, Respuesta}, which is rebuilt by concatenation each cycle.
module concatena_asigna_concatena_unit #(
  parameter int ANCHO = 3
) (
  input logic                             Reloj,
  input logic                             Reinicio,
  concatena_asigna_concatena_unit_if.slave bus
);

  localparam logic [1:0] OP_ACUMULA = 2'b00;
  localparam logic [1:0] OP_CARGA   = 2'b01;
  localparam logic [1:0] OP_ROTA    = 2'b10;
  localparam logic [1:0] OP_RETIENE = 2'b11;

  // state_q[ANCHO] is the carry flag; state_q[ANCHO-1:0] is the result.
  logic [ANCHO:0] state_q;
  logic [ANCHO:0] state_d;

  always_comb begin
    state_d = state_q;
    case (bus.Operacion)
      // The old carry is deliberately not an addend; it is overwritten by the new carry-out.
      OP_ACUMULA: state_d = {1'b0, state_q[ANCHO-1:0]} + {1'b0, bus.Tupla};
      OP_CARGA:   state_d = {1'b0, bus.Tupla};
      OP_ROTA:    state_d = {state_q[ANCHO-1:0], state_q[ANCHO]};
      OP_RETIENE: state_d = state_q;
      default:    state_d = state_q;
    endcase
  end

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.Respuesta = state_q[ANCHO-1:0];
  assign bus.Cy_Rta    = state_q[ANCHO];

endmodule

// File: tb/tb_concatena_asigna_concatena_unit.sv
// Bench for concatena_asigna_concatena_unit: directed vector table, an inter-edge stability sequence,
// and a random phase checked against a behavioural model through an expected-value queue.
module tb_concatena_asigna_concatena_unit;

  // ---------------- clock / reset ----------------
  logic Reloj = 1'b0;
  logic Reinicio;
  always #5 Reloj = ~Reloj;

  concatena_asigna_concatena_unit_if #(.ANCHO(3)) bus ();

  concatena_asigna_concatena_unit #(.ANCHO(3)) dut (
    .Reloj    (Reloj),
    .Reinicio (Reinicio),
    .bus      (bus)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] op;
    logic [2:0] tup;
    logic [2:0] r;
    logic       cy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic rst, input logic [1:0] op,
                         input logic [2:0] tup, input logic [2:0] r, input logic cy);
    vec_t v;
    v.name = n; v.rst = rst; v.op = op; v.tup = tup; v.r = r; v.cy = cy;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string n);
    logic [3:0] got;
    logic [3:0] exp;
    got = {bus.Cy_Rta, bus.Respuesta};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued, got cy=%0b r=%03b", n, got[3], got[2:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got cy=%0b r=%03b, expected cy=%0b r=%03b",
                 n, got[3], got[2:0], exp[3], exp[2:0]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string n, input logic rst, input logic [1:0] op,
                      input logic [2:0] tup, input logic [3:0] expv);
    @(negedge Reloj);
    Reinicio      = rst;
    bus.Operacion = op;
    bus.Tupla     = tup;
    exp_q.push_back(expv);
    @(posedge Reloj);
    #1;
    check_out(n);
  endtask

  // Behavioural model used for the random phase, written in integer terms.
  int m_r;
  int m_cy;

  function automatic logic [3:0] model_next(input logic rst, input logic [1:0] op, input logic [2:0] tup);
    int sum;
    int ncy;
    if (rst) begin
      m_r = 0; m_cy = 0;
    end else if (op == 2'b00) begin
      sum  = m_r + int'(tup);
      m_cy = (sum > 7) ? 1 : 0;
      m_r  = sum % 8;
    end else if (op == 2'b01) begin
      m_r = int'(tup); m_cy = 0;
    end else if (op == 2'b10) begin
      ncy  = (m_r >= 4) ? 1 : 0;
      m_r  = ((m_r * 2) % 8) + m_cy;
      m_cy = ncy;
    end
    return {m_cy[0], m_r[2:0]};
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [3:0] held;
    Reinicio      = 1'b1;
    bus.Operacion = 2'b00;
    bus.Tupla     = 3'b000;

    add_vec("reset",        1, 2'b10, 3'b101, 3'b000, 0);
    add_vec("acc4_1",       0, 2'b00, 3'b100, 3'b100, 0);
    add_vec("acc4_2",       0, 2'b00, 3'b100, 3'b000, 1);
    add_vec("acc4_3",       0, 2'b00, 3'b100, 3'b100, 0);
    add_vec("acc4_4",       0, 2'b00, 3'b100, 3'b000, 1);
    add_vec("load_111",     0, 2'b01, 3'b111, 3'b111, 0);
    add_vec("wrap_001",     0, 2'b00, 3'b001, 3'b000, 1);
    add_vec("acc_clr_cy",   0, 2'b00, 3'b010, 3'b010, 0);
    add_vec("load_101",     0, 2'b01, 3'b101, 3'b101, 0);
    add_vec("rot_1",        0, 2'b10, 3'b000, 3'b010, 1);
    add_vec("rot_2",        0, 2'b10, 3'b111, 3'b101, 0);
    add_vec("rot_3",        0, 2'b10, 3'b000, 3'b010, 1);
    add_vec("rot_4",        0, 2'b10, 3'b011, 3'b101, 0);
    add_vec("load_110",     0, 2'b01, 3'b110, 3'b110, 0);
    add_vec("hold_1",       0, 2'b11, 3'b001, 3'b110, 0);
    add_vec("hold_2",       0, 2'b11, 3'b111, 3'b110, 0);
    add_vec("hold_3",       0, 2'b11, 3'b010, 3'b110, 0);
    add_vec("reset_prio",   1, 2'b00, 3'b111, 3'b000, 0);
    add_vec("acc_after_rst",0, 2'b00, 3'b011, 3'b011, 0);
    add_vec("load_111b",    0, 2'b01, 3'b111, 3'b111, 0);
    add_vec("wrap_001b",    0, 2'b00, 3'b001, 3'b000, 1);
    add_vec("rot_carry_in", 0, 2'b10, 3'b000, 3'b001, 0);
    add_vec("load_011",     0, 2'b01, 3'b011, 3'b011, 0);
    add_vec("acc_111",      0, 2'b00, 3'b111, 3'b010, 1);
    add_vec("load_clr_cy",  0, 2'b01, 3'b000, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].tup, {vecs[i].cy, vecs[i].r});
    end

    // Inputs changed between edges must not disturb the registered outputs.
    step("pre_stable_load", 0, 2'b01, 3'b101, 4'b0101);
    held = 4'b0101;
    bus.Operacion = 2'b00;
    bus.Tupla     = 3'b111;
    #2;
    exp_q.push_back(held);
    check_out("mid_cycle_stable");
    bus.Tupla = 3'b011;
    #1;
    exp_q.push_back(held);
    check_out("mid_cycle_stable2");

    // Random phase against the behavioural model.
    void'(model_next(1'b1, 2'b00, 3'b000));
    step("rand_reset", 1, 2'b00, 3'b000, 4'b0000);
    for (int i = 0; i < 80; i++) begin
      logic       rst;
      logic [1:0] op;
      logic [2:0] tup;
      logic [3:0] e;
      rst = ($urandom_range(0, 19) == 0);
      op  = 2'($urandom_range(0, 3));
      tup = 3'($urandom_range(0, 7));
      e   = model_next(rst, op, tup);
      step("random", rst, op, tup, e);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected values never compared", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
